seq_detect_ctrl: RTL and testbench

- Armable, reconfigurable Mealy serial pattern detector with an integrated control FSM.
- The FSM loads a pattern configuration, arms and disarms detection, counts matches, and stops after a programmable match count.
- Post-reset default configuration is 1101, non-overlapping.
- Sits between a serial bit source and a host/control block that schedules detection windows.

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_match_core.sv | 46 ++++
 rtl/seq_detect_ctrl.sv | 112 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state type, reset defaults and config legality check for the sequence detector
package seq_detect_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  localparam int   DEFAULT_PATTERN = 'b1101;
  localparam int   DEFAULT_LEN     = 4;
  localparam logic DEFAULT_OVERLAP = 1'b0;

  function automatic logic len_is_legal(input int len, input int max_len);
    return (len >= 2) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// rtl/seq_match_core.sv - history shift register, fill counter and length-masked Mealy comparator
module seq_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               din,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-2:0] history;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;

  always_comb begin
    cand = {history, din};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    match = enable && (fill >= len - LEN_W'(1)) && (((cand ^ pattern) & mask) == '0);
  end

  // fill counts bits seen since the last clear; a non-overlapping match restarts it
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      history <= '0;
      fill    <= '0;
    end else if (enable) begin
      history <= (MAX_LEN-1)'({history, din});
      if (match && !overlap) begin
        fill <= '0;
      end else if (fill < len - LEN_W'(1)) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - armable serial pattern detector: control FSM, config registers, match counter
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               din,
  input  logic               din_valid,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic               arm;
  logic               match;
  logic               cfg_legal;
  logic [CNT_W-1:0]   count_inc;

  assign cfg_legal = len_is_legal(int'(cfg_len), MAX_LEN);
  assign count_inc = match_count + CNT_W'(1);

  seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
    .clk     (clk),
    .reset   (reset),
    .enable  ((state == ARMED) && din_valid),
    .clear   (arm),
    .din     (din),
    .len     (len_q),
    .pattern (pattern_q),
    .overlap (overlap_q),
    .match   (match)
  );

  always_comb begin
    state_n   = state;
    arm       = 1'b0;
    cfg_ready = (state == IDLE);
    busy      = (state == ARMED);
    done      = (state == DONE);
    dout      = match;
    case (state)
      IDLE: begin
        if (!stop && start) begin
          state_n = ARMED;
          arm     = 1'b1;
        end
      end
      ARMED: begin
        if (stop) begin
          state_n = IDLE;
        end else if (match && (target_q != '0) && (count_inc == target_q)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (start) begin
          state_n = ARMED;
          arm     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pattern_q   <= MAX_LEN'(DEFAULT_PATTERN);
      len_q       <= LEN_W'(DEFAULT_LEN);
      overlap_q   <= DEFAULT_OVERLAP;
      target_q    <= '0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state   <= state_n;
      cfg_err <= (state == IDLE) && cfg_valid && !cfg_legal;
      if ((state == IDLE) && cfg_valid && cfg_legal) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        target_q  <= cfg_target;
      end
      if (arm) begin
        match_count <= '0;
      end else if (match && (match_count != '1)) begin
        match_count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - table-driven and scripted checks of seq_detect_ctrl with a dout scoreboard
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset, cfg_valid, cfg_ready, cfg_overlap, cfg_err;
  logic [7:0] cfg_pattern, cfg_target, match_count;
  logic [3:0] cfg_len;
  logic       start, stop, din, din_valid, dout, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];

  typedef struct {
    string       name;
    logic [15:0] bits;
    int          n;
    logic [15:0] exp;
    int          cnt;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .stop(stop),
    .din(din), .din_valid(din_valid), .dout(dout), .match_count(match_count),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cfg_target  = t;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic run_stream(input string name, input logic [15:0] bits, input int n,
                            input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      din       = bits[i];
      din_valid = 1'b1;
      exp_q.push_back(exp[i]);
      @(negedge clk);
      check($sformatf("%s bit%0d dout", name, n - i), 32'(dout), 32'(exp_q.pop_front()));
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      din       = 1'b1;
      din_valid = 1'b0;
      exp_q.push_back(1'b0);
      @(negedge clk);
      check($sformatf("%s gap%0d dout", name, i), 32'(dout), 32'(exp_q.pop_front()));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"default_x2",   16'b11011101, 8, 16'b00010001, 2};
    vecs[1] = '{"nonoverlap",   16'b1101101,  7, 16'b0001000,  1};
    vecs[2] = '{"late_match",   16'b1111011,  7, 16'b0000010,  1};

    reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; stop = 1'b0; din = 1'b1; din_valid = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset cfg_ready", 32'(cfg_ready), 1);
    check("reset cfg_err", 32'(cfg_err), 0);
    check("reset count", 32'(match_count), 0);
    check("reset dout idle", 32'(dout), 0);
    tick();
    din_valid = 1'b0;

    foreach (vecs[k]) begin
      pulse_stop();
      pulse_start();
      @(negedge clk);
      check({vecs[k].name, " busy"}, 32'(busy), 1);
      check({vecs[k].name, " count0"}, 32'(match_count), 0);
      tick();
      run_stream(vecs[k].name, vecs[k].bits, vecs[k].n, vecs[k].exp);
      @(negedge clk);
      check({vecs[k].name, " count"}, 32'(match_count), 32'(vecs[k].cnt));
      tick();
    end

    pulse_stop();
    cfg_write(8'b1011, 4'd4, 1'b1, 8'd0);
    pulse_start();
    run_stream("overlap1", 16'b1011011, 7, 16'b0001001);
    @(negedge clk);
    check("overlap1 count", 32'(match_count), 2);
    tick();
    pulse_stop();
    cfg_write(8'b1011, 4'd4, 1'b0, 8'd0);
    pulse_start();
    run_stream("overlap0", 16'b1011011, 7, 16'b0001000);

    pulse_stop();
    cfg_write(8'b1101, 4'd4, 1'b0, 8'd2);
    pulse_start();
    run_stream("target a", 16'b1101, 4, 16'b0001);
    idle_cycles("target", 3);
    run_stream("target b", 16'b1101, 4, 16'b0001);
    @(negedge clk);
    check("target done", 32'(done), 1);
    check("target busy", 32'(busy), 0);
    check("target count", 32'(match_count), 2);
    tick();
    run_stream("after done", 16'b1101, 4, 16'b0000);
    @(negedge clk);
    check("held count", 32'(match_count), 2);
    tick();
    pulse_start();
    @(negedge clk);
    check("restart count", 32'(match_count), 0);
    check("restart busy", 32'(busy), 1);
    tick();

    pulse_stop();
    cfg_write(8'h01, 4'd1, 1'b1, 8'd0);
    @(negedge clk);
    check("bad len cfg_err", 32'(cfg_err), 1);
    tick();
    @(negedge clk);
    check("cfg_err one cycle", 32'(cfg_err), 0);
    tick();
    pulse_start();
    run_stream("cfg kept", 16'b1101, 4, 16'b0001);
    @(negedge clk);
    check("cfg kept busy", 32'(busy), 1);
    check("armed cfg_ready", 32'(cfg_ready), 0);
    tick();
    cfg_write(8'h00, 4'd4, 1'b0, 8'd1);
    run_stream("armed cfg ignored", 16'b1101, 4, 16'b0001);
    @(negedge clk);
    check("armed cfg done", 32'(done), 1);
    tick();
    pulse_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    check("start+stop busy", 32'(busy), 0);
    check("start+stop cfg_ready", 32'(cfg_ready), 1);
    tick();

    cfg_write(8'b111, 4'd3, 1'b0, 8'd0);
    pulse_start();
    run_stream("pre reset", 16'b11, 2, 16'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset cfg_ready", 32'(cfg_ready), 1);
    tick();
    pulse_start();
    run_stream("post reset", 16'b1101, 4, 16'b0001);
    @(negedge clk);
    check("post reset count", 32'(match_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
